// File: rtl/param_table_streamer.sv
`default_nettype none
// ============================================================================
// Module   : param_table_streamer
// Purpose  : Streams a constant 3-D table P[i][j][k] in row-major order over a
//            valid/ready port, one full walk per start request.
// Option   : define PARAM_TABLE_STREAMER_CHECKSUM_EN to add a running checksum.
// Revision : 1.0 - initial release
// ============================================================================
module param_table_streamer #(
    parameter int NI = 2,
    parameter int NJ = 3,
    parameter int NK = 4,
    // Default contents assume the default NI/NJ/NK; override P with the sizes.
    parameter int P [NI-1:0][NJ-1:0][NK-1:0] = '{
        '{ '{123, 122, 121, 120}, '{113, 112, 111, 110}, '{103, 102, 101, 100} },
        '{ '{ 23,  22,  21,  20}, '{ 13,  12,  11,  10}, '{  3,   2,   1,   0} }
    }
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [31:0]                    out_data,
    output logic [((NI > 1) ? $clog2(NI) : 1)-1:0] out_i,
    output logic [((NJ > 1) ? $clog2(NJ) : 1)-1:0] out_j,
    output logic [((NK > 1) ? $clog2(NK) : 1)-1:0] out_k,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  done
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
    , output logic [31:0]                         checksum
`endif
);

    localparam int c_IW = (NI > 1) ? $clog2(NI) : 1;
    localparam int c_JW = (NJ > 1) ? $clog2(NJ) : 1;
    localparam int c_KW = (NK > 1) ? $clog2(NK) : 1;

    localparam logic [c_IW-1:0] c_I_MAX = c_IW'(NI - 1);
    localparam logic [c_JW-1:0] c_J_MAX = c_JW'(NJ - 1);
    localparam logic [c_KW-1:0] c_K_MAX = c_KW'(NK - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_IW-1:0]    r_i;
    logic [c_JW-1:0]    r_j;
    logic [c_KW-1:0]    r_k;
    logic signed [31:0] r_data;
    logic               r_last;

    logic [1:0]         w_state_nxt;
    logic [c_IW-1:0]    w_i_nxt;
    logic [c_JW-1:0]    w_j_nxt;
    logic [c_KW-1:0]    w_k_nxt;
    logic signed [31:0] w_data_nxt;
    logic               w_last_nxt;
    logic               w_load;
    logic               w_beat;

    assign w_beat = (r_state == c_S_RUN) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_load      = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_RUN;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_k_nxt     = '0;
                    w_load      = 1'b1;
                end
            end
            c_S_RUN: begin
                if (w_beat) begin
                    if (r_last) begin
                        w_state_nxt = c_S_DONE;
                    end else begin
                        w_load = 1'b1;
                        if (r_k == c_K_MAX) begin
                            w_k_nxt = '0;
                            if (r_j == c_J_MAX) begin
                                w_j_nxt = '0;
                                w_i_nxt = r_i + 1'b1;
                            end else begin
                                w_j_nxt = r_j + 1'b1;
                            end
                        end else begin
                            w_k_nxt = r_k + 1'b1;
                        end
                    end
                end
            end
            c_S_DONE: w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase

        // Table lookup uses the next indices so out_data is purely registered.
        w_data_nxt = r_data;
        w_last_nxt = r_last;
        if (w_load) begin
            w_data_nxt = P[w_i_nxt][w_j_nxt][w_k_nxt];
            w_last_nxt = (w_i_nxt == c_I_MAX) && (w_j_nxt == c_J_MAX) && (w_k_nxt == c_K_MAX);
        end
    end

    assign out_valid = (r_state == c_S_RUN);
    assign busy      = (r_state == c_S_RUN);
    assign done      = (r_state == c_S_DONE);
    assign out_data  = r_data;
    assign out_i     = r_i;
    assign out_j     = r_j;
    assign out_k     = r_k;
    assign out_last  = r_last && out_valid;

`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == c_S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_beat) begin
            r_checksum <= r_checksum + $unsigned(r_data);
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_table_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_table_streamer
// Purpose  : Scoreboard bench for param_table_streamer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_table_streamer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               out_ready;
    logic               out_valid;
    logic signed [31:0] out_data;
    logic [0:0]         out_i;
    logic [1:0]         out_j;
    logic [1:0]         out_k;
    logic               out_last;
    logic               busy;
    logic               done;
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
    logic [31:0]        checksum;
`endif

    always #5 clk = ~clk;

    param_table_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_k     (out_k),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
        , .checksum (checksum)
`endif
    );

    typedef struct {
        int data;
        int i;
        int j;
        int k;
        bit last;
    } beat_t;

    beat_t              sb[$];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    int                 beats    = 0;
    bit                 exp_done = 1'b0;
    bit                 hold_v   = 1'b0;
    logic signed [31:0] hold_data;
    logic [31:0]        hold_idx;
    logic               hold_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] cur_idx();
        return {27'd0, out_i, out_j, out_k};
    endfunction

    // Monitor: pops the scoreboard on each beat, checks stall stability and done timing.
    always @(negedge clk) begin
        beat_t e;
        if (done === 1'b1 || exp_done) begin
            chk("done_pulse", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("done_valid", 32'(out_valid), 32'd0);
                chk("done_busy", 32'(busy), 32'd0);
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
                chk("checksum_end", checksum, 32'd1476);
`endif
            end
        end
        exp_done = 1'b0;
        if (hold_v) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, hold_data);
            chk("hold_idx", cur_idx(), hold_idx);
            chk("hold_last", 32'(out_last), 32'(hold_last));
        end
        hold_v = 1'b0;
        if (rst === 1'b0 && out_valid === 1'b1) begin
            if (out_ready === 1'b1) begin
                beats++;
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data %0d, expected no beat", out_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_idx", cur_idx(), 32'(e.i * 16 + e.j * 4 + e.k));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    if (e.last) exp_done = 1'b1;
                end
            end else begin
                hold_v    = 1'b1;
                hold_data = out_data;
                hold_idx  = cur_idx();
                hold_last = out_last;
            end
        end
    end

    task automatic push_walk();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 3; j++)
                for (int k = 0; k < 4; k++) begin
                    beat_t e;
                    e.data = 100 * i + 10 * j + k;
                    e.i    = i;
                    e.j    = j;
                    e.k    = k;
                    e.last = (i == 1 && j == 2 && k == 3);
                    sb.push_back(e);
                end
    endtask

    task automatic start_walk();
        push_walk();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_valid", 32'(out_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
        chk("checksum_cleared", checksum, 32'd0);
`endif
    endtask

    // mode 0: ready=1, 1: stall 3 cycles on 12, 2: start re-pulses, 3: random ready
    task automatic run_to_done(input int mode);
        int base   = beats;
        int stalls = 0;
        bit pulsed = 1'b0;
        bit found  = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                found = 1'b1;
                if (mode == 2) start = 1'b1;
            end else begin
                case (mode)
                    1: begin
                        if (out_valid && out_data == 12 && stalls < 3) begin
                            out_ready = 1'b0;
                            stalls++;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                    2: begin
                        out_ready = 1'b1;
                        if (beats - base == 2 && !pulsed) begin
                            start  = 1'b1;
                            pulsed = 1'b1;
                        end
                    end
                    3: out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = 1'b1;
                endcase
            end
        end
        chk("walk_finished", 32'(found), 32'd1);
        if (mode == 1) chk("stall_cycles", 32'(stalls), 32'd3);
        if (mode == 2) begin
            @(posedge clk); #1 start = 1'b0;
            chk("restart_ignored_valid", 32'(out_valid), 32'd0);
            chk("restart_ignored_busy", 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk("still_idle", 32'(out_valid), 32'd0);
        end
        chk("beat_count", 32'(beats - base), 32'd24);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_idx"}, cur_idx(), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
`ifdef PARAM_TABLE_STREAMER_CHECKSUM_EN
        chk("reset_checksum", checksum, 32'd0);
`endif
        rst       = 1'b0;
        out_ready = 1'b1;

        // Full walk, ready always high
        start_walk();
        run_to_done(0);

        // Back-pressure on entry 12
        start_walk();
        run_to_done(1);

        // Reset after the 5th beat aborts the walk
        base = beats;
        start_walk();
        for (int c = 0; c < 100; c++) begin
            if (beats - base >= 5) break;
            @(posedge clk); #1;
        end
        chk("five_beats", 32'(beats - base), 32'd5);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_cleared("abort");
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        start_walk();
        run_to_done(0);

        // Start re-pulsed mid-walk and during done
        start_walk();
        run_to_done(2);

        // Random back-pressure, two walks back to back
        start_walk();
        run_to_done(3);
        start_walk();
        run_to_done(3);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
